shifter_operand_unit: RTL

- Iterative operand-2 shifter that sits directly upstream of the datapath ALU.
- Produces the ALU B operand (`result`) and the ALU carry-in (`shifter_carry`) for data-processing instructions.
- Covers ARM-style rotated-immediate, immediate-shift and register-shift forms.
- Shifts one bit per clock under a start/done handshake, so no 32-bit barrel array is needed.

---
 rtl/shifter_operand_unit.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/shifter_operand_unit.sv
// Iterative ALU operand-2 shifter: rotated-immediate, immediate-shift and register-shift forms, one bit per clock.
// Latency N+1 cycles (N = step count, 0..33); start is ignored while busy, done pulses for one cycle.
module shifter_operand_unit #(
    parameter int WIDTH     = 32,
    parameter int MAX_STEPS = 33
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [1:0]       shift_type,
    input  logic [4:0]       shift_imm,
    input  logic [3:0]       rot_imm,
    input  logic [7:0]       imm8,
    input  logic [WIDTH-1:0] rm,
    input  logic [7:0]       rs_amt,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             shifter_carry
);

    localparam int CW = $clog2(MAX_STEPS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] MODE_ROT_IMM = 2'b00;
    localparam logic [1:0] MODE_REG_REG = 2'b10;
    localparam logic [1:0] SH_LSL       = 2'b00;
    localparam logic [1:0] SH_LSR       = 2'b01;
    localparam logic [1:0] SH_ASR       = 2'b10;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   count;
    logic            shift_left;
    logic            fill_rot;
    logic            fill_bit;
    logic            accept;
    logic            step_en;
    logic            step_fill;

    logic [WIDTH-1:0] ld_reg;
    logic             ld_carry;
    logic [CW-1:0]    ld_n;
    logic             ld_left;
    logic             ld_rot;
    logic             ld_fill;

    assign accept    = start && (state != SHIFT);
    assign step_en   = (state == SHIFT) && (count != '0);
    assign step_fill = fill_rot ? result[0] : fill_bit;
    assign busy      = (state == SHIFT);
    assign done      = (state == DONE);

    // Decode the instruction form into an initial register, carry, step count and fill policy.
    always_comb begin
        ld_reg   = rm;
        ld_carry = c_in;
        ld_n     = '0;
        ld_left  = 1'b0;
        ld_rot   = 1'b0;
        ld_fill  = 1'b0;
        if (mode == MODE_ROT_IMM) begin
            ld_reg = {{(WIDTH-8){1'b0}}, imm8};
            ld_rot = 1'b1;
            ld_n   = CW'({rot_imm, 1'b0});
        end else if (mode == MODE_REG_REG) begin
            if (rs_amt != 8'd0) begin
                case (shift_type)
                    SH_LSL: begin
                        ld_left = 1'b1;
                        ld_n    = (rs_amt >= 8'(MAX_STEPS)) ? CW'(MAX_STEPS) : CW'(rs_amt);
                    end
                    SH_LSR: begin
                        ld_n = (rs_amt >= 8'(MAX_STEPS)) ? CW'(MAX_STEPS) : CW'(rs_amt);
                    end
                    SH_ASR: begin
                        ld_fill = rm[WIDTH-1];
                        ld_n    = (rs_amt >= 8'(WIDTH)) ? CW'(WIDTH) : CW'(rs_amt);
                    end
                    default: begin
                        // ROR by a non-zero multiple of 32 leaves rm intact but still reports rm[31].
                        ld_rot = 1'b1;
                        ld_n   = CW'(rs_amt[4:0]);
                        if (rs_amt[4:0] == 5'd0) begin
                            ld_carry = rm[WIDTH-1];
                        end
                    end
                endcase
            end
        end else begin
            case (shift_type)
                SH_LSL: begin
                    ld_left = 1'b1;
                    ld_n    = CW'(shift_imm);
                end
                SH_LSR: begin
                    ld_n = (shift_imm == 5'd0) ? CW'(WIDTH) : CW'(shift_imm);
                end
                SH_ASR: begin
                    ld_fill = rm[WIDTH-1];
                    ld_n    = (shift_imm == 5'd0) ? CW'(WIDTH) : CW'(shift_imm);
                end
                default: begin
                    // ROR #0 encodes RRX: a single right step shifting in the old carry.
                    if (shift_imm == 5'd0) begin
                        ld_fill = c_in;
                        ld_n    = CW'(1);
                    end else begin
                        ld_rot = 1'b1;
                        ld_n   = CW'(shift_imm);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (count == '0) state_next = DONE;
            DONE:    state_next = start ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The output register doubles as the working register; it is only meaningful once done fires.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count         <= '0;
            result        <= '0;
            shifter_carry <= 1'b0;
            shift_left    <= 1'b0;
            fill_rot      <= 1'b0;
            fill_bit      <= 1'b0;
        end else if (accept) begin
            count         <= ld_n;
            result        <= ld_reg;
            shifter_carry <= ld_carry;
            shift_left    <= ld_left;
            fill_rot      <= ld_rot;
            fill_bit      <= ld_fill;
        end else if (step_en) begin
            count <= count - CW'(1);
            if (shift_left) begin
                shifter_carry <= result[WIDTH-1];
                result        <= {result[WIDTH-2:0], 1'b0};
            end else begin
                shifter_carry <= result[0];
                result        <= {step_fill, result[WIDTH-1:1]};
            end
        end
    end

endmodule
